gl_cmd_decoder: RTL and testbench
=================================

GL_CMD_DECODER -- requirements
Module: gl_cmd_decoder

Interface
REQ-001 SHALL have parameter MODE_W, default 2, matrix-mode select width (up to 2^MODE_W matrix stacks).
REQ-002 SHALL have parameter STACK_DEPTH, default 16, entries per matrix stack.
REQ-003 SHALL have parameter LOAD_BEATS, default 4, BRAM beats per LOADMATRIX.
REQ-004 SHALL have parameter ADDR_STEP, default 4, bram_addr_out increment per LOADMATRIX beat.
REQ-005 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; one clock, reset synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  decoder can accept.
- opcode  in  8  command opcode.
- imm  in  23  immediate.
- bram_addr_in  in  32  operand address.
- bram_read_in  in  128  packed {w3,w2,w1,w0} operand words.
- bram_addr_out  out  32  BRAM address.
- bram_mux_sel  out  1  0 = decoder drives address, 1 = matrix unit.
- mul_en  out  1  matrix-multiply start pulse.
- mul_type  out  1  1 = 4x4*4x4, 0 = 4x4*4x1.
- mul_done  in  1  multiply complete pulse.
- pdiv_en  out  1  perspective-divide start pulse.
- pdiv_done  in  1  divide complete pulse.
- load_en  out  1  matrix load strobe.
- load_id_en  out  1  load-identity pulse.
- push_en / pop_en  out  1 each  stack pulses.
- matrix_mode_out  out  MODE_W  target stack.
- color_out  out  96  packed {b,g,r}.
- viewport_out  out  128  packed {h,w,y,x}.
- fifo_write_en  out  1  transformed-vertex write pulse.
- stack_err  out  1  stack over/underflow pulse.

Function
REQ-006 SHALL accept a command on the cycle cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in IDLE and not in rst; opcode/imm/bram_addr_in SHALL be sampled only at accept.
REQ-007 SHALL register all outputs; "pulse" means high exactly one cycle, in the cycle after accept or after the triggering done.
REQ-008 Single-cycle ops (stay in IDLE): 0x10 MATRIXMODE sets curr_mode=imm[MODE_W-1:0]; 0x12 LOADID pulses load_id_en; 0x14 PUSH pulses push_en; 0x15 POP pulses pop_en; each drives matrix_mode_out=curr_mode; 0x19 VIEWPORT latches bram_read_in into viewport_out; other opcodes: no output change.
REQ-009 0x04 COLOR: bram_addr_out=bram_addr_in, bram_mux_sel=0, state COLOR_RD; next cycle color_out={w2,w1,w0}, return to IDLE (2 cycles total).
REQ-010 0x03 VERTEX: mul_en pulse, mul_type=0, matrix_mode_out=0, bram_mux_sel=0, bram_addr_out=bram_addr_in -> V_MV; on mul_done: mul_en pulse, matrix_mode_out=1 -> V_PR; on mul_done: pdiv_en pulse -> V_PD; on pdiv_done: fifo_write_en pulse -> IDLE.
REQ-011 0x11 MULTMATRIX: mul_en pulse, mul_type=1, bram_mux_sel=1, matrix_mode_out=curr_mode -> MM_WAIT; on mul_done: bram_mux_sel=0 -> IDLE.
REQ-012 0x13 LOADMATRIX: load_en high exactly LOAD_BEATS consecutive cycles, matrix_mode_out=curr_mode, bram_addr_out=bram_addr_in on first beat then +ADDR_STEP per beat (32-bit wrap) -> IDLE.
REQ-013 mul_done/pdiv_done arriving in a state not waiting for them SHALL be ignored; a done in the same cycle as its start pulse SHALL be ignored.
REQ-014 Waits SHALL be unbounded; no timeout.

Reset
REQ-015 On rst: state IDLE, curr_mode=0, all pulses/strobes/bram_mux_sel/mul_type=0, bram_addr_out=0, color_out=0, viewport_out={0x43700000,0x43A00000,0,0} (240.0, 320.0 float), stack depths=0.
REQ-016 rst mid-command SHALL abort it with no subsequent fifo_write_en, mul_en or load_en.

Configuration
REQ-017 With GL_CMD_STACK_CHECK_EN defined: per-mode depth counters (0..STACK_DEPTH-1); PUSH at STACK_DEPTH-1 or POP at 0 SHALL suppress push_en/pop_en, leave depth unchanged, and pulse stack_err.
REQ-018 Without GL_CMD_STACK_CHECK_EN: no counters, push_en/pop_en always pulse, stack_err tied 0.

Verification
REQ-019 Reset -> viewport_out={0x43700000,0x43A00000,0,0}, color_out=0, cmd_ready=1 the cycle after rst falls.
REQ-020 VERTEX, addr 0x40, mul_done after 3 and 5 cycles, pdiv_done after 2 -> two mul_en pulses (mode 0 then 1), one pdiv_en, one fifo_write_en, cmd_ready low throughout.
REQ-021 MATRIXMODE imm=2 then LOADMATRIX addr 0x100 -> load_en 4 cycles, addresses 0x100,0x104,0x108,0x10C, matrix_mode_out=2.
REQ-022 COLOR with w0..w2=0x3F800000,0,0x3F000000 -> color_out={0x3F000000,0,0x3F800000} two cycles after accept.
REQ-023 With macro, STACK_DEPTH=4: 4 PUSHes -> 3 push_en, 1 stack_err; then POP on empty other mode -> stack_err, no pop_en.
REQ-024 rst asserted in V_PR -> IDLE next cycle, later mul_done/pdiv_done produce no pulses.

Source files
------------

// File: rtl/gl_cmd_decoder.sv
// gl_cmd_decoder
// Decodes GL-style commands into control pulses for the matrix multiply unit,
// perspective divider, matrix stacks and the transformed-vertex FIFO.
//
// Ports
//   clk, rst           clock (rising edge) and synchronous active-high reset
//   cmd_valid/ready    command handshake, accepted when both are high
//   opcode, imm        command opcode and immediate
//   bram_addr_in       operand address; bram_read_in packed {w3,w2,w1,w0}
//   bram_addr_out      BRAM address; bram_mux_sel 1 hands the port to the matrix unit
//   mul_en/mul_type    multiply start pulse, 1 = 4x4*4x4, 0 = 4x4*4x1
//   mul_done           multiply complete pulse
//   pdiv_en/pdiv_done  perspective-divide start / complete pulses
//   load_en            matrix load strobe (LOAD_BEATS beats)
//   load_id_en, push_en, pop_en   matrix stack pulses
//   matrix_mode_out    target matrix stack
//   color_out          packed {b,g,r}; viewport_out packed {h,w,y,x}
//   fifo_write_en      transformed-vertex write pulse
//   stack_err          stack over/underflow pulse
//
// Build option: GL_CMD_STACK_CHECK_EN adds per-mode depth tracking and
// over/underflow detection; without it push/pop always pulse and stack_err is 0.
//
// state    | meaning
// IDLE     | ready for a command, single-cycle ops complete here
// COLOR_RD | BRAM read of colour operand in flight
// V_MV     | vertex: waiting for modelview multiply
// V_PR     | vertex: waiting for projection multiply
// V_PD     | vertex: waiting for perspective divide
// MM_WAIT  | MULTMATRIX: matrix unit owns BRAM until mul_done
// LOAD_MX  | LOADMATRIX: streaming remaining load beats

module gl_cmd_decoder #(
  parameter int MODE_W      = 2,
  parameter int STACK_DEPTH = 16,
  parameter int LOAD_BEATS  = 4,
  parameter int ADDR_STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        opcode,
  input  logic [22:0]       imm,
  input  logic [31:0]       bram_addr_in,
  input  logic [127:0]      bram_read_in,
  output logic [31:0]       bram_addr_out,
  output logic              bram_mux_sel,
  output logic              mul_en,
  output logic              mul_type,
  input  logic              mul_done,
  output logic              pdiv_en,
  input  logic              pdiv_done,
  output logic              load_en,
  output logic              load_id_en,
  output logic              push_en,
  output logic              pop_en,
  output logic [MODE_W-1:0] matrix_mode_out,
  output logic [95:0]       color_out,
  output logic [127:0]      viewport_out,
  output logic              fifo_write_en,
  output logic              stack_err
);

  localparam logic [7:0] OP_VERTEX   = 8'h03;
  localparam logic [7:0] OP_COLOR    = 8'h04;
  localparam logic [7:0] OP_MODE     = 8'h10;
  localparam logic [7:0] OP_MULTMX   = 8'h11;
  localparam logic [7:0] OP_LOADID   = 8'h12;
  localparam logic [7:0] OP_LOADMX   = 8'h13;
  localparam logic [7:0] OP_PUSH     = 8'h14;
  localparam logic [7:0] OP_POP      = 8'h15;
  localparam logic [7:0] OP_VIEWPORT = 8'h19;

  localparam logic [127:0] VIEWPORT_RST = {32'h4370_0000, 32'h43A0_0000, 32'h0, 32'h0};
  localparam int CNT_W = $clog2(LOAD_BEATS + 1);

  typedef enum logic [2:0] {IDLE, COLOR_RD, V_MV, V_PR, V_PD, MM_WAIT, LOAD_MX} state_t;

  state_t             state;
  logic [MODE_W-1:0]  curr_mode;
  logic [CNT_W-1:0]   beats_left;

`ifdef GL_CMD_STACK_CHECK_EN
  localparam int DEPTH_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  logic [DEPTH_W-1:0] depth [2**MODE_W];
`endif

  logic unused_imm;
  assign unused_imm = ^imm[22:MODE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      curr_mode       <= '0;
      beats_left      <= '0;
      cmd_ready       <= 1'b0;
      bram_addr_out   <= '0;
      bram_mux_sel    <= 1'b0;
      mul_en          <= 1'b0;
      mul_type        <= 1'b0;
      pdiv_en         <= 1'b0;
      load_en         <= 1'b0;
      load_id_en      <= 1'b0;
      push_en         <= 1'b0;
      pop_en          <= 1'b0;
      matrix_mode_out <= '0;
      color_out       <= '0;
      viewport_out    <= VIEWPORT_RST;
      fifo_write_en   <= 1'b0;
      stack_err       <= 1'b0;
`ifdef GL_CMD_STACK_CHECK_EN
      for (int i = 0; i < 2**MODE_W; i++) depth[i] <= '0;
`endif
    end else begin
      mul_en        <= 1'b0;
      pdiv_en       <= 1'b0;
      load_en       <= 1'b0;
      load_id_en    <= 1'b0;
      push_en       <= 1'b0;
      pop_en        <= 1'b0;
      fifo_write_en <= 1'b0;
      stack_err     <= 1'b0;
      cmd_ready     <= (state == IDLE) ? 1'b1 : cmd_ready;

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            case (opcode)
              OP_MODE: begin
                curr_mode       <= imm[MODE_W-1:0];
                matrix_mode_out <= imm[MODE_W-1:0];
              end
              OP_LOADID: begin
                load_id_en      <= 1'b1;
                matrix_mode_out <= curr_mode;
              end
              OP_PUSH: begin
                matrix_mode_out <= curr_mode;
`ifdef GL_CMD_STACK_CHECK_EN
                if (depth[curr_mode] == DEPTH_W'(STACK_DEPTH - 1)) begin
                  stack_err <= 1'b1;
                end else begin
                  push_en          <= 1'b1;
                  depth[curr_mode] <= depth[curr_mode] + DEPTH_W'(1);
                end
`else
                push_en <= 1'b1;
`endif
              end
              OP_POP: begin
                matrix_mode_out <= curr_mode;
`ifdef GL_CMD_STACK_CHECK_EN
                if (depth[curr_mode] == '0) begin
                  stack_err <= 1'b1;
                end else begin
                  pop_en           <= 1'b1;
                  depth[curr_mode] <= depth[curr_mode] - DEPTH_W'(1);
                end
`else
                pop_en <= 1'b1;
`endif
              end
              OP_VIEWPORT: viewport_out <= bram_read_in;
              OP_COLOR: begin
                bram_addr_out <= bram_addr_in;
                bram_mux_sel  <= 1'b0;
                cmd_ready     <= 1'b0;
                state         <= COLOR_RD;
              end
              OP_VERTEX: begin
                mul_en          <= 1'b1;
                mul_type        <= 1'b0;
                matrix_mode_out <= '0;
                bram_mux_sel    <= 1'b0;
                bram_addr_out   <= bram_addr_in;
                cmd_ready       <= 1'b0;
                state           <= V_MV;
              end
              OP_MULTMX: begin
                mul_en          <= 1'b1;
                mul_type        <= 1'b1;
                bram_mux_sel    <= 1'b1;
                matrix_mode_out <= curr_mode;
                cmd_ready       <= 1'b0;
                state           <= MM_WAIT;
              end
              OP_LOADMX: begin
                load_en         <= 1'b1;
                matrix_mode_out <= curr_mode;
                bram_mux_sel    <= 1'b0;
                bram_addr_out   <= bram_addr_in;
                beats_left      <= CNT_W'(LOAD_BEATS - 1);
                if (LOAD_BEATS > 1) begin
                  cmd_ready <= 1'b0;
                  state     <= LOAD_MX;
                end
              end
              default: ;
            endcase
          end
        end
        COLOR_RD: begin
          color_out <= bram_read_in[95:0];
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        // A done coinciding with its own start pulse belongs to an earlier
        // operation, so each wait only listens once the start pulse has dropped.
        V_MV: begin
          if (mul_done && !mul_en) begin
            mul_en          <= 1'b1;
            matrix_mode_out <= MODE_W'(1);
            state           <= V_PR;
          end
        end
        V_PR: begin
          if (mul_done && !mul_en) begin
            pdiv_en <= 1'b1;
            state   <= V_PD;
          end
        end
        V_PD: begin
          if (pdiv_done && !pdiv_en) begin
            fifo_write_en <= 1'b1;
            cmd_ready     <= 1'b1;
            state         <= IDLE;
          end
        end
        MM_WAIT: begin
          if (mul_done && !mul_en) begin
            bram_mux_sel <= 1'b0;
            cmd_ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        LOAD_MX: begin
          // Last beat is issued while returning to IDLE so the strobe stays contiguous.
          load_en       <= 1'b1;
          bram_addr_out <= bram_addr_out + 32'(ADDR_STEP);
          beats_left    <= beats_left - CNT_W'(1);
          if (beats_left == CNT_W'(1)) begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gl_cmd_decoder.sv
module tb_gl_cmd_decoder;
  localparam int MODE_W = 2;
  localparam int SD     = 4;
  localparam int LB     = 4;
  localparam int STEP   = 4;
`ifdef GL_CMD_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        opcode;
  logic [22:0]       imm;
  logic [31:0]       bram_addr_in;
  logic [127:0]      bram_read_in;
  logic [31:0]       bram_addr_out;
  logic              bram_mux_sel;
  logic              mul_en;
  logic              mul_type;
  logic              mul_done;
  logic              pdiv_en;
  logic              pdiv_done;
  logic              load_en;
  logic              load_id_en;
  logic              push_en;
  logic              pop_en;
  logic [MODE_W-1:0] matrix_mode_out;
  logic [95:0]       color_out;
  logic [127:0]      viewport_out;
  logic              fifo_write_en;
  logic              stack_err;

  gl_cmd_decoder #(.MODE_W(MODE_W), .STACK_DEPTH(SD), .LOAD_BEATS(LB), .ADDR_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .opcode(opcode), .imm(imm), .bram_addr_in(bram_addr_in), .bram_read_in(bram_read_in),
    .bram_addr_out(bram_addr_out), .bram_mux_sel(bram_mux_sel),
    .mul_en(mul_en), .mul_type(mul_type), .mul_done(mul_done),
    .pdiv_en(pdiv_en), .pdiv_done(pdiv_done), .load_en(load_en), .load_id_en(load_id_en),
    .push_en(push_en), .pop_en(pop_en), .matrix_mode_out(matrix_mode_out),
    .color_out(color_out), .viewport_out(viewport_out),
    .fifo_write_en(fifo_write_en), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor: counts high cycles mid-cycle, away from the active edge.
  int cyc = 0;
  int cnt_mul = 0, cnt_pdiv = 0, cnt_fifo = 0, cnt_load = 0;
  logic [MODE_W-1:0] mul_modes[$];
  logic [31:0]       load_addrs[$];
  logic [MODE_W-1:0] load_modes[$];
  int                load_cycs[$];

  always @(negedge clk) begin
    cyc++;
    if (mul_en) begin cnt_mul++; mul_modes.push_back(matrix_mode_out); end
    if (pdiv_en) cnt_pdiv++;
    if (fifo_write_en) cnt_fifo++;
    if (load_en) begin
      cnt_load++;
      load_addrs.push_back(bram_addr_out);
      load_modes.push_back(matrix_mode_out);
      load_cycs.push_back(cyc);
    end
  end

  // Reference state
  int           m_mode;
  int           m_depth[4];
  logic [95:0]  m_color;

  localparam logic [127:0] VP_RST = {32'h4370_0000, 32'h43A0_0000, 64'h0};

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_color = '0;
    for (int i = 0; i < 4; i++) m_depth[i] = 0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [22:0] im, input logic [31:0] a,
                       input logic [127:0] rd);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin tick(); w++; end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_ready op=%h: cmd_ready=%b required 1", op, cmd_ready);
    end
    opcode = op; imm = im; bram_addr_in = a; bram_read_in = rd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    opcode = 8'($urandom); imm = 23'($urandom); bram_addr_in = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b1; opcode = 8'h03; bram_addr_in = 32'h55;
    tick(); tick();
    n_cmp++;
    if ({cmd_ready, mul_en} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready_low: {ready,mul_en}=%b required 00", {cmd_ready, mul_en});
    end
    rst = 1'b0;
    tick();
    cmd_valid = 1'b0;
    model_reset();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b required 1", cmd_ready);
    end
    n_cmp++;
    if (viewport_out !== VP_RST) begin
      n_bad++; $display("FAIL reset_viewport: got %h required %h", viewport_out, VP_RST);
    end
    n_cmp++;
    if (color_out !== 96'h0 || bram_addr_out !== 32'h0 || matrix_mode_out !== '0) begin
      n_bad++; $display("FAIL reset_regs: color=%h addr=%h mode=%h required 0", color_out, bram_addr_out, matrix_mode_out);
    end
    n_cmp++;
    if ({mul_en, pdiv_en, load_en, load_id_en, push_en, pop_en, fifo_write_en, stack_err, bram_mux_sel, mul_type} !== 10'b0) begin
      n_bad++; $display("FAIL reset_pulses: some strobe set, required all 0");
    end
  endtask

  task automatic test_vertex(input logic [31:0] a, input int d1, input int d2, input int d3, input bit inj);
    int m0, p0, f0, qi;
    bit busy_hi;
    m0 = cnt_mul; p0 = cnt_pdiv; f0 = cnt_fifo; qi = mul_modes.size(); busy_hi = 0;
    issue(8'h03, 23'($urandom), a, rand128());
    n_cmp++;
    if ({mul_en, mul_type, bram_mux_sel, cmd_ready} !== 4'b1000 || matrix_mode_out !== 2'd0 || bram_addr_out !== a) begin
      n_bad++;
      $display("FAIL vertex_start: en/type/mux/rdy=%b mode=%0d addr=%h required 1000 0 %h",
               {mul_en, mul_type, bram_mux_sel, cmd_ready}, matrix_mode_out, bram_addr_out, a);
    end
    if (inj) begin mul_done = 1'b1; tick(); mul_done = 1'b0; busy_hi |= cmd_ready; end
    for (int i = 0; i < d1; i++) begin
      pdiv_done = inj && (i == 0); tick(); pdiv_done = 1'b0; busy_hi |= cmd_ready;
    end
    mul_done = 1'b1; tick(); mul_done = 1'b0; busy_hi |= cmd_ready;
    n_cmp++;
    if (mul_en !== 1'b1 || matrix_mode_out !== 2'd1) begin
      n_bad++; $display("FAIL vertex_proj: mul_en=%b mode=%0d required 1 1", mul_en, matrix_mode_out);
    end
    if (inj) begin mul_done = 1'b1; tick(); mul_done = 1'b0; busy_hi |= cmd_ready; end
    for (int i = 0; i < d2; i++) begin
      pdiv_done = inj && (i == 0); tick(); pdiv_done = 1'b0; busy_hi |= cmd_ready;
    end
    mul_done = 1'b1; tick(); mul_done = 1'b0; busy_hi |= cmd_ready;
    n_cmp++;
    if (pdiv_en !== 1'b1) begin
      n_bad++; $display("FAIL vertex_pdiv: pdiv_en=%b required 1", pdiv_en);
    end
    if (inj) begin pdiv_done = 1'b1; tick(); pdiv_done = 1'b0; busy_hi |= cmd_ready; end
    for (int i = 0; i < d3; i++) begin
      mul_done = inj && (i == 0); tick(); mul_done = 1'b0; busy_hi |= cmd_ready;
    end
    pdiv_done = 1'b1; tick(); pdiv_done = 1'b0;
    n_cmp++;
    if (fifo_write_en !== 1'b1 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL vertex_fifo: fifo=%b ready=%b required 1 1", fifo_write_en, cmd_ready);
    end
    tick();
    n_cmp++;
    if (busy_hi) begin
      n_bad++; $display("FAIL vertex_busy: cmd_ready seen 1 while busy, required 0");
    end
    n_cmp++;
    if (cnt_mul - m0 != 2 || cnt_pdiv - p0 != 1 || cnt_fifo - f0 != 1) begin
      n_bad++; $display("FAIL vertex_counts: mul=%0d pdiv=%0d fifo=%0d required 2 1 1",
                        cnt_mul - m0, cnt_pdiv - p0, cnt_fifo - f0);
    end
    n_cmp++;
    if (mul_modes.size() < qi + 2 || mul_modes[qi] !== 2'd0 || mul_modes[qi+1] !== 2'd1) begin
      n_bad++; $display("FAIL vertex_modes: pulses with modes other than 0 then 1 (n=%0d)", mul_modes.size() - qi);
    end
  endtask

  task automatic test_loadmatrix(input int m, input logic [31:0] a);
    int qi, n;
    logic [31:0] exp_a;
    qi = load_addrs.size();
    issue(8'h10, {21'($urandom), 2'(m)}, $urandom, rand128());
    m_mode = m;
    issue(8'h13, 23'($urandom), a, rand128());
    for (int i = 0; i < LB + 3; i++) tick();
    n = load_addrs.size() - qi;
    n_cmp++;
    if (n != LB) begin
      n_bad++; $display("FAIL load_beats: got %0d required %0d", n, LB);
    end
    for (int i = 0; i < LB && qi + i < load_addrs.size(); i++) begin
      exp_a = a + 32'(i * STEP);
      n_cmp++;
      if (load_addrs[qi+i] !== exp_a || load_modes[qi+i] !== 2'(m) || load_cycs[qi+i] != load_cycs[qi] + i) begin
        n_bad++;
        $display("FAIL load_beat%0d: addr=%h mode=%0d cyc+%0d required %h %0d cyc+%0d",
                 i, load_addrs[qi+i], load_modes[qi+i], load_cycs[qi+i] - load_cycs[qi], exp_a, m, i);
      end
    end
  endtask

  task automatic test_color(input logic [31:0] a, input logic [127:0] rd);
    issue(8'h04, 23'($urandom), a, rd);
    n_cmp++;
    if (bram_addr_out !== a || bram_mux_sel !== 1'b0 || cmd_ready !== 1'b0 || color_out !== m_color) begin
      n_bad++; $display("FAIL color_rd: addr=%h mux=%b rdy=%b color=%h required %h 0 0 %h",
                        bram_addr_out, bram_mux_sel, cmd_ready, color_out, a, m_color);
    end
    tick();
    m_color = {rd[95:64], rd[63:32], rd[31:0]};
    n_cmp++;
    if (color_out !== m_color || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL color_out: got %h rdy=%b required %h 1", color_out, cmd_ready, m_color);
    end
  endtask

  task automatic test_viewport();
    logic [127:0] rd;
    rd = rand128();
    issue(8'h19, 23'($urandom), $urandom, rd);
    n_cmp++;
    if (viewport_out !== rd || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL viewport: got %h rdy=%b required %h 1", viewport_out, cmd_ready, rd);
    end
  endtask

  task automatic test_multmatrix(input int d, input bit inj);
    int m0;
    bit mux_drop;
    m0 = cnt_mul; mux_drop = 0;
    issue(8'h11, 23'($urandom), $urandom, rand128());
    n_cmp++;
    if ({mul_en, mul_type, bram_mux_sel, cmd_ready} !== 4'b1110 || matrix_mode_out !== 2'(m_mode)) begin
      n_bad++; $display("FAIL mm_start: en/type/mux/rdy=%b mode=%0d required 1110 %0d",
                        {mul_en, mul_type, bram_mux_sel, cmd_ready}, matrix_mode_out, m_mode);
    end
    if (inj) begin mul_done = 1'b1; tick(); mul_done = 1'b0; mux_drop |= !bram_mux_sel; end
    for (int i = 0; i < d; i++) begin
      pdiv_done = inj && (i == 0); tick(); pdiv_done = 1'b0; mux_drop |= !bram_mux_sel;
    end
    n_cmp++;
    if (mux_drop) begin
      n_bad++; $display("FAIL mm_hold: bram_mux_sel dropped before mul_done, required 1");
    end
    mul_done = 1'b1; tick(); mul_done = 1'b0;
    n_cmp++;
    if (bram_mux_sel !== 1'b0 || cmd_ready !== 1'b1 || cnt_mul - m0 != 1) begin
      n_bad++; $display("FAIL mm_done: mux=%b rdy=%b mul_pulses=%0d required 0 1 1",
                        bram_mux_sel, cmd_ready, cnt_mul - m0);
    end
  endtask

  // op: 0 push, 1 pop, 2 matrixmode, 3 loadid
  task automatic stack_op(input int op, input int arg);
    logic [3:0] exp_p;
    exp_p = 4'b0000;  // {push_en, pop_en, stack_err, load_id_en}
    case (op)
      0: begin
        if (CHK && m_depth[m_mode] == SD - 1) exp_p = 4'b0010;
        else begin exp_p = 4'b1000; m_depth[m_mode]++; end
        issue(8'h14, 23'($urandom), $urandom, rand128());
      end
      1: begin
        if (CHK && m_depth[m_mode] == 0) exp_p = 4'b0010;
        else begin exp_p = 4'b0100; if (m_depth[m_mode] > 0) m_depth[m_mode]--; end
        issue(8'h15, 23'($urandom), $urandom, rand128());
      end
      2: begin
        m_mode = arg;
        issue(8'h10, {21'($urandom), 2'(arg)}, $urandom, rand128());
      end
      default: begin
        exp_p = 4'b0001;
        issue(8'h12, 23'($urandom), $urandom, rand128());
      end
    endcase
    n_cmp++;
    if ({push_en, pop_en, stack_err, load_id_en} !== exp_p || (op != 2 && matrix_mode_out !== 2'(m_mode))) begin
      n_bad++; $display("FAIL stack_op%0d mode%0d: {push,pop,err,ldid}=%b mode=%0d required %b %0d",
                        op, m_mode, {push_en, pop_en, stack_err, load_id_en}, matrix_mode_out, exp_p, m_mode);
    end
  endtask

  task automatic test_stack();
    test_reset();
    stack_op(2, 1);
    for (int i = 0; i < 4; i++) stack_op(0, 0);
    stack_op(2, 3);
    stack_op(1, 0);
    for (int i = 0; i < 40; i++) stack_op($urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_unknown();
    logic [7:0] op;
    logic [359:0] snap;
    for (int k = 0; k < 6; k++) begin
      do op = 8'($urandom); while (op inside {8'h03, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h19});
      tick();
      snap = {bram_addr_out, bram_mux_sel, mul_en, mul_type, pdiv_en, load_en, load_id_en, push_en, pop_en,
              matrix_mode_out, color_out, viewport_out, fifo_write_en, stack_err, 90'h0};
      issue(op, 23'($urandom), $urandom, rand128());
      n_cmp++;
      if ({bram_addr_out, bram_mux_sel, mul_en, mul_type, pdiv_en, load_en, load_id_en, push_en, pop_en,
           matrix_mode_out, color_out, viewport_out, fifo_write_en, stack_err, 90'h0} !== snap || cmd_ready !== 1'b1) begin
        n_bad++; $display("FAIL unknown_op %h: outputs changed or ready=%b, required unchanged and 1", op, cmd_ready);
      end
    end
  endtask

  task automatic test_reset_abort();
    int m0, p0, f0, l0;
    issue(8'h03, 23'($urandom), 32'h80, rand128());
    tick(); tick();
    mul_done = 1'b1; tick(); mul_done = 1'b0;
    tick();
    rst = 1'b1; tick();
    n_cmp++;
    if ({cmd_ready, mul_en, pdiv_en, fifo_write_en} !== 4'b0000) begin
      n_bad++; $display("FAIL abort_in_rst: {rdy,mul,pdiv,fifo}=%b required 0000", {cmd_ready, mul_en, pdiv_en, fifo_write_en});
    end
    rst = 1'b0; tick();
    model_reset();
    n_cmp++;
    if (cmd_ready !== 1'b1 || viewport_out !== VP_RST) begin
      n_bad++; $display("FAIL abort_idle: rdy=%b vp=%h required 1 %h", cmd_ready, viewport_out, VP_RST);
    end
    m0 = cnt_mul; p0 = cnt_pdiv; f0 = cnt_fifo; l0 = cnt_load;
    tick();
    mul_done = 1'b1; tick(); mul_done = 1'b0;
    tick(); tick();
    pdiv_done = 1'b1; tick(); pdiv_done = 1'b0;
    mul_done = 1'b1; tick(); mul_done = 1'b0;
    tick(); tick();
    n_cmp++;
    if (cnt_mul != m0 || cnt_pdiv != p0 || cnt_fifo != f0 || cnt_load != l0) begin
      n_bad++; $display("FAIL abort_quiet: mul=%0d pdiv=%0d fifo=%0d load=%0d pulses after reset, required 0",
                        cnt_mul - m0, cnt_pdiv - p0, cnt_fifo - f0, cnt_load - l0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; opcode = '0; imm = '0; bram_addr_in = '0;
    bram_read_in = '0; mul_done = 1'b0; pdiv_done = 1'b0;
    model_reset();
    test_reset();
    test_vertex(32'h40, 3, 5, 2, 1'b0);
    for (int i = 0; i < 6; i++)
      test_vertex($urandom, $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), 1'($urandom));
    test_loadmatrix(2, 32'h100);
    test_loadmatrix(int'($urandom_range(0, 3)), 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) test_loadmatrix(int'($urandom_range(0, 3)), $urandom);
    test_color(32'h20, {32'h0, 32'h3F00_0000, 32'h0, 32'h3F80_0000});
    for (int i = 0; i < 4; i++) test_color($urandom, rand128());
    for (int i = 0; i < 3; i++) test_viewport();
    test_multmatrix(3, 1'b0);
    for (int i = 0; i < 4; i++) test_multmatrix($urandom_range(1, 5), 1'($urandom));
    test_unknown();
    test_stack();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
